alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 126 ++++++++++++
 tb/tb_alu_result_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry in-order buffer between the ALU and writeback,
// computing {N,Z,C,V} per word and committing them to the flag register on retire.
module alu_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic        in_cout,
  input  logic        in_cin15,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic        in_setflags,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_rd,
  output logic [3:0]  flags
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_W   = 3;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam logic [2:0]  OP_ADDSUB = 3'b011;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic [FLAG_W-1:0] fl;
    logic              setflags;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic               rd_ptr_q, rd_ptr_n;
  logic               wr_ptr_q, wr_ptr_n;
  logic [FLAG_W-1:0]  flags_n;
  logic               out_valid_n;
  logic [DATA_W-1:0]  out_result_n;
  logic [RD_W-1:0]    out_rd_n;

  logic               push_c;
  logic               pop_c;
  logic [FLAG_W-1:0]  new_flags_c;
  entry_t             new_entry_c;

  // Ready depends only on occupancy and reset, never on out_ready.
  assign in_ready = ~rst & (count_q != CNT_W'(DEPTH));
  assign push_c   = in_valid & in_ready;
  assign pop_c    = out_valid & out_ready;

  // Carry and overflow are only meaningful for ADD/SUB; logic ops clear them.
  always_comb begin
    new_flags_c = '0;
    new_flags_c[3] = in_result[DATA_W-1];
    new_flags_c[2] = (in_result == '0);
    if (in_op == OP_ADDSUB) begin
      new_flags_c[1] = in_cout;
      new_flags_c[0] = in_cout ^ in_cin15;
    end
    new_entry_c.result   = in_result;
    new_entry_c.rd       = in_rd;
    new_entry_c.fl       = new_flags_c;
    new_entry_c.setflags = in_setflags;
  end

  // Next-state: flush drops everything including a same-cycle push and commit.
  always_comb begin
    mem_n    = mem_q;
    count_n  = count_q;
    rd_ptr_n = rd_ptr_q;
    wr_ptr_n = wr_ptr_q;
    flags_n  = flags;
    if (flush) begin
      count_n  = '0;
      rd_ptr_n = 1'b0;
      wr_ptr_n = 1'b0;
    end else begin
      if (push_c) begin
        mem_n[wr_ptr_q] = new_entry_c;
        wr_ptr_n        = wr_ptr_q + 1'b1;
      end
      if (pop_c) begin
        rd_ptr_n = rd_ptr_q + 1'b1;
        if (mem_q[rd_ptr_q].setflags) begin
          flags_n = mem_q[rd_ptr_q].fl;
        end
      end
      count_n = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
    out_valid_n  = (count_n != '0);
    out_result_n = '0;
    out_rd_n     = '0;
    if (out_valid_n) begin
      out_result_n = mem_n[rd_ptr_n].result;
      out_rd_n     = mem_n[rd_ptr_n].rd;
    end
  end

  // Head presentation is registered from the post-update head.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      count_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      flags      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else begin
      mem_q      <= mem_n;
      count_q    <= count_n;
      rd_ptr_q   <= rd_ptr_n;
      wr_ptr_q   <= wr_ptr_n;
      flags      <= flags_n;
      out_valid  <= out_valid_n;
      out_result <= out_result_n;
      out_rd     <= out_rd_n;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic checked
// against a queue-based model of the buffer and flag register.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_cout, in_cin15, in_setflags, flush;
  logic        out_valid, out_ready;
  logic [15:0] in_result, out_result;
  logic [2:0]  in_op, in_rd, out_rd;
  logic [3:0]  flags;

  alu_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_cout(in_cout), .in_cin15(in_cin15),
    .in_op(in_op), .in_rd(in_rd), .in_setflags(in_setflags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  rd;
    logic [3:0]  fl;
    bit          sf;
  } ent_t;

  ent_t        q[$];
  int          popped[$];
  logic [3:0]  mflags;
  bit          last_push;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [15:0] res, input logic [2:0] op,
                                             input logic cout, input logic cin15);
    bit n, z, c, v;
    n = $signed(res) < 0;
    z = (res == 16'd0);
    c = (op == 3'd3) ? cout : 1'b0;
    v = (op == 3'd3) ? (cout != cin15) : 1'b0;
    return {n, z, c, v};
  endfunction

  task automatic compare();
    check("out_valid", out_valid, q.size() != 0);
    check("out_result", out_result, q.size() != 0 ? q[0].res : 16'd0);
    check("out_rd", out_rd, q.size() != 0 ? q[0].rd : 3'd0);
    check("flags", flags, mflags);
    check("in_ready", in_ready, !rst && q.size() < 2);
  endtask

  // One clock: decide handshakes from the pre-edge model, then update and compare.
  task automatic step();
    bit push, pop;
    ent_t e;
    push = in_valid && !rst && q.size() < 2;
    pop  = out_ready && q.size() > 0;
    e.res = in_result;
    e.rd  = in_rd;
    e.fl  = model_flags(in_result, in_op, in_cout, in_cin15);
    e.sf  = in_setflags;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      mflags = 4'd0;
      push = 0;
    end else if (flush) begin
      q.delete();
      push = 0;
    end else begin
      if (pop) begin
        ent_t h;
        h = q.pop_front();
        popped.push_back(int'(h.rd));
        if (h.sf) mflags = h.fl;
      end
      if (push) q.push_back(e);
    end
    last_push = push;
    compare();
  endtask

  task automatic word(input logic [15:0] res, input logic [2:0] op, input logic cout,
                      input logic cin15, input logic [2:0] rd, input logic sf);
    in_valid = 1'b1; in_result = res; in_op = op; in_cout = cout;
    in_cin15 = cin15; in_rd = rd; in_setflags = sf;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_result = 0; in_cout = 0; in_cin15 = 0;
    in_op = 0; in_rd = 0; in_setflags = 0; flush = 0; out_ready = 0;
    mflags = 4'd0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 16'h0000);
    check("rst_flags", flags, 4'b0000);

    // Signed overflow on ADD.
    out_ready = 1'b1;
    word(16'h8000, 3'b011, 1'b0, 1'b1, 3'd4, 1'b1);
    step();
    check("ovf_valid", out_valid, 1);
    check("ovf_result", out_result, 16'h8000);
    in_valid = 1'b0;
    step();
    check("ovf_flags", flags, 4'b1001);

    // Logic op: zero result, carry suppressed.
    word(16'h0000, 3'b010, 1'b1, 1'b0, 3'd1, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("xor_flags", flags, 4'b0100);

    // Backpressure with a third word held upstream.
    out_ready = 1'b0;
    word(16'h1111, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0);
    step();
    word(16'h2222, 3'b001, 1'b0, 1'b0, 3'd2, 1'b0);
    step();
    check("bp_full_ready", in_ready, 0);
    word(16'h3333, 3'b011, 1'b1, 1'b1, 3'd3, 1'b0);
    step();
    step();
    popped.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (in_valid || q.size() != 0); i++) begin
      step();
      if (last_push) in_valid = 1'b0;
    end
    check("bp_pop_count", popped.size(), 3);
    for (int i = 0; i < 3; i++)
      check("bp_order", i < popped.size() ? popped[i] : -1, i + 1);

    // Simultaneous push and pop at count 1.
    out_ready = 1'b0;
    word(16'h00a5, 3'b011, 1'b1, 1'b1, 3'd5, 1'b0);
    step();
    out_ready = 1'b1;
    word(16'hff00, 3'b011, 1'b1, 1'b0, 3'd6, 1'b0);
    step();
    check("pp_valid", out_valid, 1);
    check("pp_ready", in_ready, 1);
    check("pp_head", out_rd, 6);
    in_valid = 1'b0;
    step();
    check("pp_flags_hold", flags, 4'b0100);

    // Flush at count 2 with a same-cycle push.
    out_ready = 1'b0;
    word(16'h8001, 3'b011, 1'b1, 1'b0, 3'd1, 1'b1);
    step();
    word(16'h8002, 3'b011, 1'b1, 1'b0, 3'd2, 1'b1);
    step();
    flush = 1'b1; out_ready = 1'b1;
    word(16'h8003, 3'b011, 1'b0, 1'b1, 3'd3, 1'b1);
    step();
    check("flush_valid", out_valid, 0);
    check("flush_flags", flags, 4'b0100);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_after", out_valid, 0);

    // Reset mid-operation at count 2.
    out_ready = 1'b0;
    word(16'hffff, 3'b011, 1'b1, 1'b1, 3'd7, 1'b1);
    step();
    step();
    rst = 1'b1; out_ready = 1'b1;
    step();
    check("mrst_valid", out_valid, 0);
    check("mrst_result", out_result, 0);
    check("mrst_rd", out_rd, 0);
    check("mrst_flags", flags, 0);
    check("mrst_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid    = $urandom_range(0, 1);
      in_result   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      in_op       = 3'($urandom_range(0, 7));
      in_cout     = $urandom_range(0, 1);
      in_cin15    = $urandom_range(0, 1);
      in_rd       = 3'($urandom_range(0, 7));
      in_setflags = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
